// File: rtl/e203_exu_brslv_flush.sv
// Commit-side branch resolver: decides on pipeline flushes, computes the redirect PC,
// holds the flush request until the IFU acknowledges it, and counts mispredictions.
module e203_exu_brslv_flush #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmt_i_valid,
  output logic             cmt_i_ready,
  input  logic             cmt_i_rv32,
  input  logic             cmt_i_bjp,
  input  logic             cmt_i_bjp_prdt,
  input  logic             cmt_i_bjp_rslv,
  input  logic             cmt_i_mret,
  input  logic             cmt_i_dret,
  input  logic             cmt_i_fencei,
  input  logic [PC_W-1:0]  cmt_i_pc,
  input  logic [PC_W-1:0]  cmt_i_imm,
  input  logic [PC_W-1:0]  csr_epc_r,
  input  logic [PC_W-1:0]  csr_dpc_r,
  output logic             flush_req,
  input  logic             flush_ack,
  output logic [PC_W-1:0]  flush_pc,
  output logic             cmt_mret_ena,
  output logic             cmt_dret_ena,
  output logic             cmt_fencei_ena,
  output logic             nonflush_cmt_ena,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
  typedef enum logic [1:0] {C_BJP = 2'd0, C_MRET = 2'd1, C_DRET = 2'd2, C_FENCEI = 2'd3} cause_t;

  state_t            state_q;
  cause_t            cause_q;
  cause_t            cause_d;
  logic [PC_W-1:0]   target_d;
  logic [PC_W-1:0]   flush_pc_q;
  logic [PC_W-1:0]   seq_pc;
  logic [CNT_W-1:0]  cnt_q;
  logic              flush_req_q;
  logic              mret_ena_q;
  logic              dret_ena_q;
  logic              fencei_ena_q;
  logic              nonflush_q;
  logic              accept;
  logic              mispred;
  logic              need_flush;

  assign accept     = cmt_i_valid & cmt_i_ready;
  assign mispred    = cmt_i_bjp & (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv);
  assign need_flush = cmt_i_mret | cmt_i_dret | cmt_i_fencei | mispred;
  assign seq_pc     = cmt_i_pc + (cmt_i_rv32 ? PC_W'(4) : PC_W'(2));

  // Redirect target and cause, highest-priority flag first
  always_comb begin
    target_d = seq_pc;
    cause_d  = C_BJP;
    if (cmt_i_dret) begin
      target_d = csr_dpc_r;
      cause_d  = C_DRET;
    end else if (cmt_i_mret) begin
      target_d = csr_epc_r;
      cause_d  = C_MRET;
    end else if (cmt_i_fencei) begin
      cause_d  = C_FENCEI;
    end else if (cmt_i_bjp_rslv) begin
      target_d = cmt_i_pc + cmt_i_imm;
    end
  end

  // Flush FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cause_q      <= C_BJP;
      flush_pc_q   <= '0;
      flush_req_q  <= 1'b0;
      mret_ena_q   <= 1'b0;
      dret_ena_q   <= 1'b0;
      fencei_ena_q <= 1'b0;
      nonflush_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      mret_ena_q   <= 1'b0;
      dret_ena_q   <= 1'b0;
      fencei_ena_q <= 1'b0;
      nonflush_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (need_flush) begin
              state_q     <= REQ;
              flush_req_q <= 1'b1;
              flush_pc_q  <= target_d;
              cause_q     <= cause_d;
              if ((cause_d == C_BJP) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else begin
              nonflush_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (flush_ack) begin
            state_q     <= IDLE;
            flush_req_q <= 1'b0;
            case (cause_q)
              C_MRET:   mret_ena_q   <= 1'b1;
              C_DRET:   dret_ena_q   <= 1'b1;
              C_FENCEI: fencei_ena_q <= 1'b1;
              default:  ;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmt_i_ready      = (state_q == IDLE);
  assign flush_req        = flush_req_q;
  assign flush_pc         = flush_pc_q;
  assign cmt_mret_ena     = mret_ena_q;
  assign cmt_dret_ena     = dret_ena_q;
  assign cmt_fencei_ena   = fencei_ena_q;
  assign nonflush_cmt_ena = nonflush_q;
  assign mispred_cnt      = cnt_q;

endmodule

// File: tb/tb_e203_exu_brslv_flush.sv
// Bench for the commit-side branch resolver: directed vector table, corner-case
// sequences, and randomized traffic against a behavioural model.
module tb_e203_exu_brslv_flush;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = 15;

  // kind encoding: 0 none, 1 mret, 2 dret, 3 fencei, 4 bjp mispredict
  typedef struct {
    logic        rv32, bjp, prdt, rslv, mret, dret, fencei;
    logic [31:0] pc, imm, epc, dpc;
    logic        exp_flush;
    logic [31:0] exp_pc;
    int          exp_kind;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmt_i_valid, cmt_i_ready, cmt_i_rv32, cmt_i_bjp, cmt_i_bjp_prdt;
  logic             cmt_i_bjp_rslv, cmt_i_mret, cmt_i_dret, cmt_i_fencei;
  logic [PC_W-1:0]  cmt_i_pc, cmt_i_imm, csr_epc_r, csr_dpc_r, flush_pc;
  logic             flush_req, flush_ack;
  logic             cmt_mret_ena, cmt_dret_ena, cmt_fencei_ena, nonflush_cmt_ena;
  logic [CNT_W-1:0] mispred_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int tb_cnt   = 0;

  always #5 clk = ~clk;

  e203_exu_brslv_flush #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmt_i_valid(cmt_i_valid), .cmt_i_ready(cmt_i_ready),
    .cmt_i_rv32(cmt_i_rv32), .cmt_i_bjp(cmt_i_bjp),
    .cmt_i_bjp_prdt(cmt_i_bjp_prdt), .cmt_i_bjp_rslv(cmt_i_bjp_rslv),
    .cmt_i_mret(cmt_i_mret), .cmt_i_dret(cmt_i_dret), .cmt_i_fencei(cmt_i_fencei),
    .cmt_i_pc(cmt_i_pc), .cmt_i_imm(cmt_i_imm),
    .csr_epc_r(csr_epc_r), .csr_dpc_r(csr_dpc_r),
    .flush_req(flush_req), .flush_ack(flush_ack), .flush_pc(flush_pc),
    .cmt_mret_ena(cmt_mret_ena), .cmt_dret_ena(cmt_dret_ena),
    .cmt_fencei_ena(cmt_fencei_ena), .nonflush_cmt_ena(nonflush_cmt_ena),
    .mispred_cnt(mispred_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    cmt_i_valid = 0; cmt_i_rv32 = 1; cmt_i_bjp = 0; cmt_i_bjp_prdt = 0; cmt_i_bjp_rslv = 0;
    cmt_i_mret = 0; cmt_i_dret = 0; cmt_i_fencei = 0;
    cmt_i_pc = '0; cmt_i_imm = '0; csr_epc_r = '0; csr_dpc_r = '0; flush_ack = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    cmt_i_rv32 = v.rv32; cmt_i_bjp = v.bjp; cmt_i_bjp_prdt = v.prdt; cmt_i_bjp_rslv = v.rslv;
    cmt_i_mret = v.mret; cmt_i_dret = v.dret; cmt_i_fencei = v.fencei;
    cmt_i_pc = v.pc; cmt_i_imm = v.imm; csr_epc_r = v.epc; csr_dpc_r = v.dpc;
  endtask

  task automatic chk_pulses(input string nm, input int kind);
    chk({nm, ".mret_ena"},   32'(cmt_mret_ena),   32'(kind == 1));
    chk({nm, ".dret_ena"},   32'(cmt_dret_ena),   32'(kind == 2));
    chk({nm, ".fencei_ena"}, 32'(cmt_fencei_ena), 32'(kind == 3));
  endtask

  // Applies one vector from IDLE, acks any flush at once, checks every step
  task automatic run_vec(input string nm, input vec_t v);
    drive_vec(v);
    cmt_i_valid = 1;
    tick();
    cmt_i_valid = 0;
    if (v.exp_kind == 4 && tb_cnt < CMAX) tb_cnt++;
    chk({nm, ".flush_req"}, 32'(flush_req), 32'(v.exp_flush));
    chk({nm, ".nonflush"}, 32'(nonflush_cmt_ena), 32'(!v.exp_flush));
    chk({nm, ".cnt"}, 32'(mispred_cnt), 32'(tb_cnt));
    if (v.exp_flush) begin
      chk({nm, ".flush_pc"}, flush_pc, v.exp_pc);
      chk({nm, ".ready"}, 32'(cmt_i_ready), 32'd0);
      flush_ack = 1;
      tick();
      flush_ack = 0;
      chk({nm, ".req_clr"}, 32'(flush_req), 32'd0);
      chk({nm, ".ready_back"}, 32'(cmt_i_ready), 32'd1);
      chk_pulses(nm, v.exp_kind);
      tick();
      chk_pulses({nm, ".after"}, 0);
    end else begin
      chk_pulses(nm, 0);
      tick();
      chk({nm, ".nonflush_off"}, 32'(nonflush_cmt_ena), 32'd0);
    end
  endtask

  // Behavioural model state for the randomized phase
  logic        m_busy;
  logic [31:0] m_pc;
  int          m_kind;
  int          m_pulse;
  logic        m_nonflush;

  initial begin
    vec_t vecs[9];
    vec_t v;

    //            rv32 bjp prdt rslv mret dret fi  pc            imm           epc           dpc           flush pc           kind
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0100, 32'h0000_0040, 32'h0, 32'h0, 1'b1, 32'h8000_0140, 4};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 32'h0000_2002, 4};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 32'h0,         0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_4000, 32'h0,         32'h1234_5678, 32'h0, 1'b1, 32'h1234_5678, 1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0,         32'h1234_5678, 32'hDEAD_BEE0, 1'b1, 32'hDEAD_BEE0, 2};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0,         32'h0, 32'h0, 1'b1, 32'h0000_0002, 3};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_5000, 32'h0,         32'h0, 32'h0, 1'b0, 32'h0,         0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_6000, 32'h0000_0080, 32'hAAAA_0000, 32'h0, 1'b1, 32'hAAAA_0000, 1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0, 32'h0, 1'b1, 32'h0000_0010, 4};

    clear_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst.flush_req", 32'(flush_req), 32'd0);
    chk("rst.flush_pc", flush_pc, 32'd0);
    chk("rst.cnt", 32'(mispred_cnt), 32'd0);
    chk("rst.nonflush", 32'(nonflush_cmt_ena), 32'd0);
    chk_pulses("rst", 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst.ready", 32'(cmt_i_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Request held without ack; commits offered during REQ are ignored
    v = vecs[0];
    drive_vec(v);
    cmt_i_valid = 1;
    tick();
    if (tb_cnt < CMAX) tb_cnt++;
    cmt_i_mret = 1; csr_epc_r = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold.req", 32'(flush_req), 32'd1);
      chk("hold.pc", flush_pc, 32'h8000_0140);
      chk("hold.ready", 32'(cmt_i_ready), 32'd0);
      chk("hold.cnt", 32'(mispred_cnt), 32'(tb_cnt));
    end
    cmt_i_valid = 0; cmt_i_mret = 0;
    flush_ack = 1;
    tick();
    chk("hold.ack_req", 32'(flush_req), 32'd0);
    chk("hold.ack_ready", 32'(cmt_i_ready), 32'd1);
    chk_pulses("hold.ack", 0);
    // ack while idle has no effect
    tick();
    flush_ack = 0;
    chk("idle_ack.req", 32'(flush_req), 32'd0);
    chk_pulses("idle_ack", 0);

    // Back-to-back non-flush commits give consecutive pulses
    drive_vec(vecs[2]);
    cmt_i_valid = 1;
    tick();
    chk("b2b.nf0", 32'(nonflush_cmt_ena), 32'd1);
    tick();
    chk("b2b.nf1", 32'(nonflush_cmt_ena), 32'd1);
    cmt_i_valid = 0;
    tick();
    chk("b2b.nf_off", 32'(nonflush_cmt_ena), 32'd0);

    // Asynchronous reset in REQ drops the request immediately
    drive_vec(vecs[0]);
    cmt_i_valid = 1;
    tick();
    cmt_i_valid = 0;
    chk("arst.pre_req", 32'(flush_req), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("arst.req", 32'(flush_req), 32'd0);
    chk("arst.pc", flush_pc, 32'd0);
    chk("arst.cnt", 32'(mispred_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1;
    tb_cnt = 0;
    @(negedge clk);
    chk("arst.ready", 32'(cmt_i_ready), 32'd1);

    // Saturation: 17 mispredictions on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      drive_vec(vecs[1]);
      cmt_i_valid = 1;
      tick();
      cmt_i_valid = 0;
      flush_ack = 1;
      tick();
      flush_ack = 0;
      if (i == 14) chk("sat.at15", 32'(mispred_cnt), 32'd15);
    end
    chk("sat.final", 32'(mispred_cnt), 32'hF);
    tb_cnt = CMAX;

    // Randomized traffic against the behavioural model
    m_busy = 0; m_pc = '0; m_kind = 0; m_pulse = 0; m_nonflush = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] tgt;
      int          kind;
      cmt_i_valid    = ($urandom_range(0, 9) < 6);
      cmt_i_rv32     = 1'($urandom_range(0, 1));
      cmt_i_bjp      = 1'($urandom_range(0, 1));
      cmt_i_bjp_prdt = 1'($urandom_range(0, 1));
      cmt_i_bjp_rslv = 1'($urandom_range(0, 1));
      cmt_i_mret     = ($urandom_range(0, 7) == 0);
      cmt_i_dret     = ($urandom_range(0, 7) == 0);
      cmt_i_fencei   = ($urandom_range(0, 7) == 0);
      cmt_i_pc       = $urandom;
      cmt_i_imm      = $urandom;
      csr_epc_r      = $urandom;
      csr_dpc_r      = $urandom;
      flush_ack      = 1'($urandom_range(0, 1));
      // Predict the effect of the coming clock edge
      m_pulse = 0;
      m_nonflush = 0;
      if (!m_busy) begin
        if (cmt_i_valid) begin
          kind = 0;
          tgt  = cmt_i_pc + (cmt_i_rv32 ? 32'd4 : 32'd2);
          if (cmt_i_dret) begin kind = 2; tgt = csr_dpc_r; end
          else if (cmt_i_mret) begin kind = 1; tgt = csr_epc_r; end
          else if (cmt_i_fencei) kind = 3;
          else if (cmt_i_bjp && (cmt_i_bjp_prdt != cmt_i_bjp_rslv)) begin
            kind = 4;
            if (cmt_i_bjp_rslv) tgt = cmt_i_pc + cmt_i_imm;
          end
          if (kind != 0) begin
            m_busy = 1; m_pc = tgt; m_kind = kind;
            if (kind == 4 && tb_cnt < CMAX) tb_cnt++;
          end else begin
            m_nonflush = 1;
          end
        end
      end else if (flush_ack) begin
        m_busy  = 0;
        m_pulse = (m_kind == 4) ? 0 : m_kind;
      end
      tick();
      chk("rnd.req", 32'(flush_req), 32'(m_busy));
      chk("rnd.ready", 32'(cmt_i_ready), 32'(!m_busy));
      if (m_busy) chk("rnd.pc", flush_pc, m_pc);
      chk("rnd.nonflush", 32'(nonflush_cmt_ena), 32'(m_nonflush));
      chk("rnd.cnt", 32'(mispred_cnt), 32'(tb_cnt));
      chk_pulses("rnd", m_pulse);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
